// File: rtl/npusch_dmrs_re_mapper_if.sv
`default_nettype none
// ============================================================================
// npusch_dmrs_re_mapper_if : DMRS in, data in and RE out handshake bundle
// Revision : 1.0
// ============================================================================
interface npusch_dmrs_re_mapper_if #(
  parameter int DATA_W = 32
);
  logic              dmrs_valid;
  logic [DATA_W-1:0] dmrs_re;
  logic [DATA_W-1:0] dmrs_im;
  logic              dmrs_ready;

  logic              data_valid;
  logic [DATA_W-1:0] data_re;
  logic [DATA_W-1:0] data_im;
  logic              data_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [3:0]        out_sc;
  logic [2:0]        out_sym;
  logic              out_is_dmrs;
  logic              out_slot_start;
  logic [7:0]        out_slot;
  logic              out_ready;

  modport master (
    output dmrs_valid, dmrs_re, dmrs_im,
    output data_valid, data_re, data_im,
    output out_ready,
    input  dmrs_ready, data_ready,
    input  out_valid, out_re, out_im, out_sc, out_sym,
    input  out_is_dmrs, out_slot_start, out_slot
  );

  modport slave (
    input  dmrs_valid, dmrs_re, dmrs_im,
    input  data_valid, data_re, data_im,
    input  out_ready,
    output dmrs_ready, data_ready,
    output out_valid, out_re, out_im, out_sc, out_sym,
    output out_is_dmrs, out_slot_start, out_slot
  );
endinterface
`default_nettype wire

// File: rtl/npusch_dmrs_re_mapper.sv
`default_nettype none
// ============================================================================
// npusch_dmrs_re_mapper : merges NPUSCH data and buffered DMRS into a
//                         slot-ordered RE stream for the SC-FDMA stage
// Revision : 1.0
// ============================================================================
module npusch_dmrs_re_mapper #(
  parameter int DATA_W     = 32,
  parameter int N_SC       = 12,
  parameter int N_SYM      = 7,
  parameter int DMRS_SYM   = 3,
  parameter int FIFO_DEPTH = 16
) (
  input wire clk,
  input wire rst_n,
  npusch_dmrs_re_mapper_if.slave bus
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  SC_LAST   = 4'(N_SC - 1);
  localparam logic [2:0]  SYM_LAST  = 3'(N_SYM - 1);
  localparam logic [2:0]  SYM_DMRS  = 3'(DMRS_SYM);
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  // DMRS buffer: pointers carry one extra wrap bit so full and empty differ
  logic [DATA_W-1:0] fifo_re [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_im [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       fill;
  logic              full;
  logic              empty;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              alive;

  logic [3:0]        sc;
  logic [2:0]        sym;
  logic [7:0]        slot;
  logic              is_dmrs_sym;
  logic              src_avail;
  logic              load_en;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_re_q;
  logic [DATA_W-1:0] out_im_q;
  logic [3:0]        out_sc_q;
  logic [2:0]        out_sym_q;
  logic              out_is_dmrs_q;
  logic              out_slot_start_q;
  logic [7:0]        out_slot_q;

  assign fill        = wr_ptr - rd_ptr;
  assign full        = (fill == FIFO_FULL);
  assign empty       = (fill == '0);
  assign fifo_wr     = bus.dmrs_valid && bus.dmrs_ready;

  assign is_dmrs_sym = (sym == SYM_DMRS);
  assign src_avail   = is_dmrs_sym ? !empty : bus.data_valid;
  assign load_en     = (!out_valid_q || bus.out_ready) && src_avail;
  assign fifo_rd     = load_en && is_dmrs_sym;

  assign bus.dmrs_ready     = alive && !full;
  assign bus.data_ready     = load_en && !is_dmrs_sym;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_re         = out_re_q;
  assign bus.out_im         = out_im_q;
  assign bus.out_sc         = out_sc_q;
  assign bus.out_sym        = out_sym_q;
  assign bus.out_is_dmrs    = out_is_dmrs_q;
  assign bus.out_slot_start = out_slot_start_q;
  assign bus.out_slot       = out_slot_q;

  // Holds dmrs_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_re[wr_ptr[AW-1:0]] <= bus.dmrs_re;
      fifo_im[wr_ptr[AW-1:0]] <= bus.dmrs_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Slot position advances once per RE loaded into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc   <= '0;
      sym  <= '0;
      slot <= '0;
    end else if (load_en) begin
      if (sc == SC_LAST) begin
        sc <= '0;
        if (sym == SYM_LAST) begin
          sym  <= '0;
          slot <= slot + 8'd1;
        end else begin
          sym <= sym + 3'd1;
        end
      end else begin
        sc <= sc + 4'd1;
      end
    end
  end

  // Payload fields only change on a load, so a dropped out_valid keeps them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_re_q         <= '0;
      out_im_q         <= '0;
      out_sc_q         <= '0;
      out_sym_q        <= '0;
      out_is_dmrs_q    <= 1'b0;
      out_slot_start_q <= 1'b0;
      out_slot_q       <= '0;
    end else begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_q <= src_avail;
      end
      if (load_en) begin
        out_re_q         <= is_dmrs_sym ? fifo_re[rd_ptr[AW-1:0]] : bus.data_re;
        out_im_q         <= is_dmrs_sym ? fifo_im[rd_ptr[AW-1:0]] : bus.data_im;
        out_sc_q         <= sc;
        out_sym_q        <= sym;
        out_is_dmrs_q    <= is_dmrs_sym;
        out_slot_start_q <= (sym == 3'd0) && (sc == 4'd0);
        out_slot_q       <= slot;
      end
    end
  end

endmodule
`default_nettype wire
